// File: rtl/fir_out_buffer.sv
// FIR output buffer: FIFO between the FIR stream and the sink, with frame-length tracking and tlast enforcement.
// Optional FIR_OUT_BUFFER_PEAK_EN adds a peak |sample| tracker on port peak_abs.
module fir_out_buffer #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int pCNT_WIDTH  = 12
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst,
    input  logic                      ss_tvalid,
    input  logic [pDATA_WIDTH-1:0]    ss_tdata,
    input  logic                      ss_tlast,
    output logic                      ss_tready,
    output logic                      sm_tvalid,
    output logic [pDATA_WIDTH-1:0]    sm_tdata,
    output logic                      sm_tlast,
    input  logic                      sm_tready,
    input  logic [pCNT_WIDTH-1:0]     cfg_len,
    input  logic                      clr,
    output logic [pCNT_WIDTH-1:0]     sample_cnt,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      frame_done,
    output logic                      len_err
`ifdef FIR_OUT_BUFFER_PEAK_EN
    ,
    output logic [pDATA_WIDTH-1:0]    peak_abs
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, RUN} state_e;

    logic [pDATA_WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  ready_q;
    state_e                state_q, state_d;
    logic [pCNT_WIDTH-1:0] cnt_q, cnt_d, cnt_sat;
    logic [pCNT_WIDTH:0]   cnt_inc;
    logic                  len_err_q, len_err_d;
    logic                  frame_done_q;
    logic                  push, pop, len_hit, early, missing, tlast_in;

    assign push      = ss_tvalid && ready_q;
    assign pop       = sm_tvalid && sm_tready;
    assign ss_tready = ready_q;
    assign sm_tvalid = (level_q != '0);
    assign {sm_tlast, sm_tdata} = sm_tvalid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign sample_cnt = cnt_q;
    assign frame_done = frame_done_q;
    assign len_err    = len_err_q;

    // Compare count+1 one bit wider so a saturated counter never aliases cfg_len.
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
    assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign len_hit  = (cfg_len != '0) && (cnt_inc == {1'b0, cfg_len});
    assign early    = ss_tlast && (cfg_len != '0) && (cnt_inc < {1'b0, cfg_len});
    assign missing  = len_hit && !ss_tlast;
    assign tlast_in = ss_tlast || len_hit;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (push) begin
                state_d = tlast_in ? IDLE : RUN;
                cnt_d   = tlast_in ? '0 : pCNT_WIDTH'(1);
            end
            RUN: if (push) begin
                state_d = tlast_in ? IDLE : RUN;
                cnt_d   = tlast_in ? '0 : cnt_sat;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A new error in the same cycle as clr takes precedence.
    assign len_err_d = (clr ? 1'b0 : len_err_q) | (push && (early || missing));

    always_ff @(posedge axis_clk) begin
        if (push) mem_q[wr_ptr_q] <= {tlast_in, ss_tdata};
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ready_q      <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q      <= level_d;
            ready_q      <= (level_d < LW'(DEPTH));
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
            frame_done_q <= pop && sm_tlast;
        end
    end

`ifdef FIR_OUT_BUFFER_PEAK_EN
    logic [pDATA_WIDTH-1:0] mag, peak_q, peak_d;

    // The most-negative value has no positive twin; clamp to the largest positive.
    always_comb begin
        mag = ss_tdata;
        if (ss_tdata[pDATA_WIDTH-1]) begin
            if (ss_tdata == {1'b1, {(pDATA_WIDTH-1){1'b0}}})
                mag = {1'b0, {(pDATA_WIDTH-1){1'b1}}};
            else
                mag = -ss_tdata;
        end
    end

    always_comb begin
        peak_d = peak_q;
        if (clr)
            peak_d = push ? mag : '0;
        else if (push && (mag > peak_q))
            peak_d = mag;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) peak_q <= '0;
        else          peak_q <= peak_d;
    end

    assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Self-checking bench for fir_out_buffer: scoreboard of expected {tlast,data} beats plus per-scenario tasks.
module tb_fir_out_buffer;
    localparam int DW = 32;
    localparam int CW = 12;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0] ss_tdata;
    logic          sm_tvalid, sm_tlast, sm_tready;
    logic [DW-1:0] sm_tdata;
    logic [CW-1:0] cfg_len, sample_cnt;
    logic          clr, frame_done, len_err;
    logic [4:0]    level;
`ifdef FIR_OUT_BUFFER_PEAK_EN
    logic [DW-1:0] peak_abs;
`endif

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    logic [DW:0] exp_q [$];

    always #5 axis_clk = ~axis_clk;

    fir_out_buffer #(.pDATA_WIDTH(DW), .DEPTH(16), .pCNT_WIDTH(CW)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .cfg_len(cfg_len), .clr(clr), .sample_cnt(sample_cnt), .level(level),
        .frame_done(frame_done), .len_err(len_err)
`ifdef FIR_OUT_BUFFER_PEAK_EN
        , .peak_abs(peak_abs)
`endif
    );

    // Output side of the scoreboard: every completed output beat must match the oldest expectation.
    always @(negedge axis_clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (!axis_rst && sm_tvalid === 1'b1 && sm_tready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat: got data=%0d last=%0b, expected no beat", sm_tdata, sm_tlast);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({sm_tlast, sm_tdata} !== e) begin
                    errors++;
                    $display("FAIL out_beat: got data=%0d last=%0b, expected data=%0d last=%0b",
                             sm_tdata, sm_tlast, e[DW-1:0], e[DW]);
                end
            end
        end
    end

    // Starts and ends one time unit after a rising edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic el);
        int n = 0;
        ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = l;
        @(negedge axis_clk);
        while (ss_tready !== 1'b1 && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        if (ss_tready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: ss_tready=%0b after %0d cycles, expected 1", ss_tready, n);
        end else begin
            exp_q.push_back({el, d});
        end
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || sm_tvalid !== 1'b0) && n < 500) begin
            @(posedge axis_clk); #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
        end
        repeat (2) begin @(posedge axis_clk); #1; end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge axis_clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        axis_rst = 1'b1;
        repeat (3) @(posedge axis_clk);
        #1;
        checks++;
        if ({ss_tready, sm_tvalid, sm_tlast, frame_done, len_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got rdy/vld/last/fd/err=%b, expected 00000",
                     {ss_tready, sm_tvalid, sm_tlast, frame_done, len_err});
        end
        checks++;
        if (level !== 5'd0 || sample_cnt !== 12'd0 || sm_tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got level=%0d cnt=%0d data=%0d, expected 0 0 0", level, sample_cnt, sm_tdata);
        end
        axis_rst = 1'b0;
        @(posedge axis_clk); #1;
    endtask

    task automatic test_basic_frame();
        int fd0 = fd_cnt;
        cfg_len = 12'd4; sm_tready = 1'b1;
        send_beat(32'd1, 1'b0, 1'b0);
        checks++;
        if (sm_tvalid !== 1'b1 || sm_tdata !== 32'd1) begin
            errors++;
            $display("FAIL basic_latency: got vld=%0b data=%0d, expected 1 1", sm_tvalid, sm_tdata);
        end
        send_beat(32'd2, 1'b0, 1'b0);
        checks++;
        if (sample_cnt !== 12'd2) begin
            errors++;
            $display("FAIL basic_midcnt: got %0d, expected 2", sample_cnt);
        end
        send_beat(32'd3, 1'b0, 1'b0);
        send_beat(32'd4, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (fd_cnt - fd0 !== 1 || len_err !== 1'b0 || sample_cnt !== 12'd0) begin
            errors++;
            $display("FAIL basic_end: got fd=%0d err=%0b cnt=%0d, expected 1 0 0", fd_cnt - fd0, len_err, sample_cnt);
        end
    endtask

    task automatic test_back_to_back();
        cfg_len = 12'd0; sm_tready = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(DW'(i), 1'b0, 1'b0);
        checks++;
        if (ss_tready !== 1'b0 || level !== 5'd16) begin
            errors++;
            $display("FAIL full: got ready=%0b level=%0d, expected 0 16", ss_tready, level);
        end
        sm_tready = 1'b1;
        for (int i = 16; i < 20; i++) send_beat(DW'(i), (i == 19), (i == 19));
        wait_drain();
        checks++;
        if (level !== 5'd0 || ss_tready !== 1'b1) begin
            errors++;
            $display("FAIL drained: got level=%0d ready=%0b, expected 0 1", level, ss_tready);
        end
    endtask

    task automatic test_early_tlast();
        cfg_len = 12'd5;
        send_beat(32'd31, 1'b0, 1'b0);
        send_beat(32'd32, 1'b0, 1'b0);
        send_beat(32'd33, 1'b1, 1'b1);
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL early_err: got %0b, expected 1", len_err);
        end
        send_beat(32'd41, 1'b0, 1'b0);
        checks++;
        if (sample_cnt !== 12'd1) begin
            errors++;
            $display("FAIL early_recount: got %0d, expected 1", sample_cnt);
        end
        for (int i = 2; i <= 5; i++) send_beat(DW'(40 + i), (i == 5), (i == 5));
        wait_drain();
        pulse_clr();
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL early_clr: got %0b, expected 0", len_err);
        end
    endtask

    task automatic test_forced_tlast();
        int fd0 = fd_cnt;
        cfg_len = 12'd3;
        for (int i = 1; i <= 6; i++) send_beat(DW'(100 + i), 1'b0, (i == 3 || i == 6));
        wait_drain();
        checks++;
        if (fd_cnt - fd0 !== 2 || len_err !== 1'b1 || sample_cnt !== 12'd0) begin
            errors++;
            $display("FAIL forced: got fd=%0d err=%0b cnt=%0d, expected 2 1 0", fd_cnt - fd0, len_err, sample_cnt);
        end
    endtask

    task automatic test_passthrough();
        int fd0;
        pulse_clr();
        fd0 = fd_cnt;
        cfg_len = 12'd0;
        for (int i = 1; i <= 2; i++) send_beat(DW'(200 + i), (i == 2), (i == 2));
        for (int i = 1; i <= 7; i++) send_beat(-DW'(i), (i == 7), (i == 7));
        wait_drain();
        checks++;
        if (fd_cnt - fd0 !== 2 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: got fd=%0d err=%0b, expected 2 0", fd_cnt - fd0, len_err);
        end
    endtask

    task automatic test_reset_midframe();
        int fd0;
        cfg_len = 12'd0; sm_tready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(DW'(300 + i), 1'b0, 1'b0);
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL mid_level: got %0d, expected 5", level);
        end
        fd0 = fd_cnt;
        axis_rst = 1'b1;
        @(posedge axis_clk); #1;
        exp_q.delete();
        checks++;
        if (level !== 5'd0 || sm_tvalid !== 1'b0 || sample_cnt !== 12'd0 || ss_tready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got level=%0d vld=%0b cnt=%0d rdy=%0b, expected 0 0 0 0",
                     level, sm_tvalid, sample_cnt, ss_tready);
        end
        axis_rst = 1'b0;
        sm_tready = 1'b1; cfg_len = 12'd2;
        send_beat(32'd401, 1'b0, 1'b0);
        send_beat(32'd402, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (fd_cnt - fd0 !== 1 || len_err !== 1'b0 || sample_cnt !== 12'd0) begin
            errors++;
            $display("FAIL post_reset: got fd=%0d err=%0b cnt=%0d, expected 1 0 0", fd_cnt - fd0, len_err, sample_cnt);
        end
    endtask

`ifdef FIR_OUT_BUFFER_PEAK_EN
    task automatic test_peak();
        pulse_clr();
        cfg_len = 12'd0;
        send_beat(-32'sd7, 1'b0, 1'b0);
        send_beat(32'd3, 1'b0, 1'b0);
        send_beat(-32'sd2, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (peak_abs !== 32'd7) begin
            errors++;
            $display("FAIL peak: got %0d, expected 7", peak_abs);
        end
        send_beat(32'h8000_0000, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (peak_abs !== 32'h7fff_ffff) begin
            errors++;
            $display("FAIL peak_sat: got %h, expected 7fffffff", peak_abs);
        end
        pulse_clr();
        checks++;
        if (peak_abs !== 32'd0) begin
            errors++;
            $display("FAIL peak_clr: got %0d, expected 0", peak_abs);
        end
    endtask
`endif

    initial begin
        ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
        sm_tready = 1'b0; cfg_len = '0; clr = 1'b0; axis_rst = 1'b1;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_early_tlast();
        test_forced_tlast();
        test_passthrough();
        test_reset_midframe();
`ifdef FIR_OUT_BUFFER_PEAK_EN
        test_peak();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending beats, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
